// File: rtl/iir_wb_master_if.sv
// ---------------------------------------------------------------------------
// iir_wb_master_if
//   Wishbone B3 classic bus bundle between iir_wb_master and the IIR filter
//   slave. The clock and reset are not part of the bundle; they stay as plain
//   ports on the modules that use it.
//
//   adr    master -> slave  32  byte address
//   dat_w  master -> slave  32  write data
//   sel    master -> slave   4  byte selects
//   cyc    master -> slave   1  bus cycle
//   stb    master -> slave   1  strobe
//   we     master -> slave   1  write enable
//   dat_r  slave -> master  32  read data
//   ack    slave -> master   1  acknowledge
//   err    slave -> master   1  bus error
// ---------------------------------------------------------------------------
interface iir_wb_master_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, cyc, stb, we,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, cyc, stb, we,
    output dat_r, ack, err
  );
endinterface

// File: rtl/iir_wb_master.sv
// ---------------------------------------------------------------------------
// iir_wb_master
//   Wishbone B3 classic single-beat master that runs one job on the IIR
//   filter slave: loads NSAMP samples from a local sample buffer, pulses the
//   slave's "next" register, polls data_valid, then reads NSAMP results back
//   into a local result buffer.
//
//   Ports
//     wb_clk_i    in   clock
//     wb_rst_i    in   asynchronous reset, active low
//     start_i     in   one-cycle start pulse, accepted only when idle
//     smp_we_i    in   host write strobe into the sample buffer
//     smp_addr_i  in   sample buffer index
//     smp_dat_i   in   sample value
//     res_addr_i  in   result buffer read index
//     res_dat_o   out  result value (combinational read)
//     busy_o      out  high from start acceptance until done or error
//     done_o      out  one-cycle pulse at the end of a successful run
//     err_o       out  sticky error flag, cleared by the next accepted start
//     wb          --   Wishbone master bundle (iir_wb_master_if.master)
//
//   Each transaction costs one issue cycle (cyc/stb low, request registered)
//   plus the cycles with cyc/stb high up to and including the ack/err cycle.
//
//   Optional build macro IIR_WB_MASTER_TIMEOUT_EN: adds an ack watchdog
//   (ACK_MAX stalled cycles) and a poll limit (POLL_MAX failed polls); either
//   one aborts the run like a bus error. Without it the master waits forever.
// ---------------------------------------------------------------------------
module iir_wb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NSAMP     = 32,
  parameter int unsigned POLL_MAX  = 1024,
  parameter int unsigned ACK_MAX   = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start_i,
  input  logic                 smp_we_i,
  input  logic [4:0]           smp_addr_i,
  input  logic [31:0]          smp_dat_i,
  input  logic [4:0]           res_addr_i,
  output logic [31:0]          res_dat_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  iir_wb_master_if.master      wb
);

  localparam int unsigned DATA_W = 32;

  // Slave register offsets
  localparam logic [31:0] OFF_NEXT  = 32'h00;
  localparam logic [31:0] OFF_DATAW = 32'h04;
  localparam logic [31:0] OFF_WADDR = 32'h08;
  localparam logic [31:0] OFF_WDATA = 32'h0C;
  localparam logic [31:0] OFF_RADDR = 32'h10;  // write: read address, read: data_valid
  localparam logic [31:0] OFF_RDATA = 32'h1C;

  localparam logic [4:0] LAST_IDX = 5'(NSAMP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_L_ADR, S_L_DAT, S_L_WS, S_L_WC,
    S_N_S, S_N_C, S_POLL, S_R_ADR, S_R_DAT, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          idx_q, idx_d;
  logic                cyc_q, cyc_d;
  logic                we_q, we_d;
  logic [31:0]         adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                res_we;
  logic                abort;

  logic [31:0]         iss_off;
  logic                iss_we;
  logic [DATA_W-1:0]   iss_dat;

  logic [DATA_W-1:0]   smp_mem [0:31];
  logic [DATA_W-1:0]   res_mem [0:31];

`ifdef IIR_WB_MASTER_TIMEOUT_EN
  logic [31:0]         ack_cnt_q, ack_cnt_d;
  logic [31:0]         poll_cnt_q, poll_cnt_d;
`else
  logic [63:0]         unused_timeout_params;
  assign unused_timeout_params = {32'(POLL_MAX), 32'(ACK_MAX)};
`endif

  // Request issued by each bus state
  always_comb begin
    iss_off = OFF_NEXT;
    iss_we  = 1'b1;
    iss_dat = '0;
    case (state_q)
      S_L_ADR: begin iss_off = OFF_WADDR; iss_dat = {27'd0, idx_q}; end
      S_L_DAT: begin iss_off = OFF_WDATA; iss_dat = smp_mem[idx_q]; end
      S_L_WS:  begin iss_off = OFF_DATAW; iss_dat = 32'd1;          end
      S_L_WC:  begin iss_off = OFF_DATAW; iss_dat = 32'd0;          end
      S_N_S:   begin iss_off = OFF_NEXT;  iss_dat = 32'd1;          end
      S_N_C:   begin iss_off = OFF_NEXT;  iss_dat = 32'd0;          end
      S_POLL:  begin iss_off = OFF_RADDR; iss_we  = 1'b0;           end
      S_R_ADR: begin iss_off = OFF_RADDR; iss_dat = {27'd0, idx_q}; end
      S_R_DAT: begin iss_off = OFF_RDATA; iss_we  = 1'b0;           end
      default: ;
    endcase
  end

  // Next-state and bus control
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    res_we  = 1'b0;
    abort   = 1'b0;
`ifdef IIR_WB_MASTER_TIMEOUT_EN
    ack_cnt_d  = '0;
    poll_cnt_d = poll_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_L_ADR;
`ifdef IIR_WB_MASTER_TIMEOUT_EN
          poll_cnt_d = '0;
`endif
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        if (!cyc_q) begin
          // Issue cycle: this also provides the one idle cycle between transactions
          cyc_d = 1'b1;
          we_d  = iss_we;
          adr_d = BASE_ADDR + iss_off;
          dat_d = iss_dat;
        end else begin
`ifdef IIR_WB_MASTER_TIMEOUT_EN
          if (!wb.ack && !wb.err) begin
            if (ack_cnt_q == ACK_MAX - 1) abort = 1'b1;
            else                          ack_cnt_d = ack_cnt_q + 32'd1;
          end
`endif
          if (wb.err) begin
            abort = 1'b1;
          end else if (wb.ack) begin
            cyc_d = 1'b0;
            case (state_q)
              S_L_ADR: state_d = S_L_DAT;
              S_L_DAT: state_d = S_L_WS;
              S_L_WS:  state_d = S_L_WC;
              S_L_WC: begin
                if (idx_q == LAST_IDX) state_d = S_N_S;
                else begin idx_d = idx_q + 5'd1; state_d = S_L_ADR; end
              end
              S_N_S: state_d = S_N_C;
              S_N_C: begin idx_d = '0; state_d = S_POLL; end
              S_POLL: begin
                if (wb.dat_r[0]) state_d = S_R_ADR;
`ifdef IIR_WB_MASTER_TIMEOUT_EN
                else if (poll_cnt_q == POLL_MAX - 1) abort = 1'b1;
                else poll_cnt_d = poll_cnt_q + 32'd1;
`endif
              end
              S_R_ADR: state_d = S_R_DAT;
              S_R_DAT: begin
                res_we = 1'b1;
                if (idx_q == LAST_IDX) state_d = S_DONE;
                else begin idx_d = idx_q + 5'd1; state_d = S_R_ADR; end
              end
              default: ;
            endcase
          end
          if (abort) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            res_we  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef IIR_WB_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack_cnt_q  <= '0;
      poll_cnt_q <= '0;
    end else begin
      ack_cnt_q  <= ack_cnt_d;
      poll_cnt_q <= poll_cnt_d;
    end
  end
`endif

  // Buffers hold data only and are deliberately left unreset
  always_ff @(posedge wb_clk_i) begin
    if (smp_we_i) smp_mem[smp_addr_i] <= smp_dat_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (res_we) res_mem[idx_q] <= wb.dat_r;
  end

  assign res_dat_o = res_mem[res_addr_i];
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;

  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;
  assign wb.sel   = 4'hF;
  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = we_q;

endmodule

// File: tb/tb_iir_wb_master.sv
// ---------------------------------------------------------------------------
// tb_iir_wb_master
//   Directed bench for iir_wb_master with a behavioural IIR slave model.
//   The slave filters y[k] = x[k] + (y[k-1] >> 1) over what it was sent.
// ---------------------------------------------------------------------------
module tb_iir_wb_master;

  localparam logic [31:0] TB_BASE = 32'h0000_1000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start_i;
  logic        smp_we_i;
  logic [4:0]  smp_addr_i;
  logic [31:0] smp_dat_i;
  logic [4:0]  res_addr_i;
  logic [31:0] res_dat_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 wb_clk_i = ~wb_clk_i;

  iir_wb_master_if wb ();

  iir_wb_master #(
    .BASE_ADDR (TB_BASE),
    .NSAMP     (32),
    .POLL_MAX  (4),
    .ACK_MAX   (255)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start_i    (start_i),
    .smp_we_i   (smp_we_i),
    .smp_addr_i (smp_addr_i),
    .smp_dat_i  (smp_dat_i),
    .res_addr_i (res_addr_i),
    .res_dat_o  (res_dat_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .wb         (wb)
  );

  int tests = 0;
  int fails = 0;

  // Slave controls (written only by the stimulus process)
  int ack_delay   = 0;
  int err_at      = -1;
  int valid_delay = 10;
  bit valid_never = 1'b0;
  bit slv_clr     = 1'b1;

  // Slave state and monitors (written only by the slave process)
  logic [31:0] s_mem [0:31];
  logic [31:0] s_out [0:31];
  logic [31:0] s_waddr, s_wdata, s_raddr;
  bit          s_valid, s_armed;
  int          s_vcnt, wait_cnt, wr_cnt;
  int          wr0c_cnt, next_cnt, poll_reads, done_cnt;
  logic [31:0] wr0c_dat [0:63];
  logic [31:0] next_log [0:7];
  int          stb_run, gap_run, stb_min, stb_max, gap_min, gap_max;
  bit          stb_prev, have_fall;

  logic [31:0] samp [0:31];
  logic [31:0] off;
  logic        hit, is_err;

  assign off    = wb.adr - TB_BASE;
  assign hit    = wb.cyc && wb.stb && (wait_cnt >= ack_delay);
  assign is_err = wb.we && (wr_cnt == err_at);
  assign wb.ack = hit && !is_err;
  assign wb.err = hit && is_err;

  always_comb begin
    wb.dat_r = 32'd0;
    if (off == 32'h10)      wb.dat_r = {31'd0, s_valid};
    else if (off == 32'h1C) wb.dat_r = s_out[s_raddr[4:0]];
  end

  always_comb begin
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 32; k++) begin
      acc      = s_mem[k] + (acc >> 1);
      s_out[k] = acc;
    end
  end

  always @(posedge wb_clk_i) begin
    if (slv_clr) begin
      s_waddr <= 0; s_wdata <= 0; s_raddr <= 0;
      s_valid <= 0; s_armed <= 0; s_vcnt <= 0;
      wait_cnt <= 0; wr_cnt <= 0;
      wr0c_cnt <= 0; next_cnt <= 0; poll_reads <= 0; done_cnt <= 0;
      stb_run <= 0; gap_run <= 0; stb_min <= 1000; stb_max <= 0;
      gap_min <= 1000; gap_max <= 0; stb_prev <= 0; have_fall <= 0;
    end else begin
      if (wb.cyc && wb.stb && !(wb.ack || wb.err)) wait_cnt <= wait_cnt + 1;
      else                                         wait_cnt <= 0;
      if (wb.cyc && wb.stb && (wb.ack || wb.err) && wb.we) wr_cnt <= wr_cnt + 1;
      if (s_vcnt > 0) begin
        if (s_vcnt == 1) s_valid <= !valid_never;
        s_vcnt <= s_vcnt - 1;
      end
      if (wb.ack && wb.we) begin
        case (off)
          32'h08: s_waddr <= wb.dat_w;
          32'h0C: begin
            s_wdata <= wb.dat_w;
            if (wr0c_cnt < 64) wr0c_dat[wr0c_cnt] <= wb.dat_w;
            wr0c_cnt <= wr0c_cnt + 1;
          end
          32'h04: if (wb.dat_w == 32'd1) s_mem[s_waddr[4:0]] <= s_wdata;
          32'h00: begin
            if (next_cnt < 8) next_log[next_cnt] <= wb.dat_w;
            next_cnt <= next_cnt + 1;
            if (wb.dat_w == 32'd1) begin
              s_armed <= 1; s_valid <= 0;
            end else if (s_armed) begin
              s_armed <= 0;
              if (valid_delay == 0) s_valid <= !valid_never;
              else                  s_vcnt  <= valid_delay;
            end
          end
          32'h10: s_raddr <= wb.dat_w;
          default: ;
        endcase
      end
      if (wb.ack && !wb.we && off == 32'h10) poll_reads <= poll_reads + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      // strobe-high and strobe-low run lengths between transactions
      stb_prev <= wb.stb;
      if (wb.stb) begin
        if (!stb_prev && have_fall) begin
          if (gap_run < gap_min) gap_min <= gap_run;
          if (gap_run > gap_max) gap_max <= gap_run;
        end
        stb_run <= stb_run + 1;
        gap_run <= 0;
      end else begin
        if (stb_prev) begin
          if (stb_run < stb_min) stb_min <= stb_run;
          if (stb_run > stb_max) stb_max <= stb_run;
          have_fall <= 1;
        end
        stb_run <= 0;
        gap_run <= gap_run + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_slave();
    slv_clr = 1'b1;
    @(posedge wb_clk_i); #1;
    slv_clr = 1'b0;
  endtask

  task automatic load_samples(input int mult, input int add);
    for (int k = 0; k < 32; k++) begin
      samp[k]    = 32'(k * mult + add);
      smp_we_i   = 1'b1;
      smp_addr_i = 5'(k);
      smp_dat_i  = samp[k];
      @(posedge wb_clk_i); #1;
    end
    smp_we_i = 1'b0;
  endtask

  task automatic start_run();
    start_i = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(posedge wb_clk_i); #1;
      n++;
    end while (done_o !== 1'b1 && n < budget);
  endtask

  task automatic check_results(input string tag);
    logic [31:0] acc;
    acc = 32'd0;
    for (int k = 0; k < 32; k++) begin
      acc        = samp[k] + (acc >> 1);
      res_addr_i = 5'(k);
      #1;
      check($sformatf("%s res[%0d]", tag, k), res_dat_o, acc);
    end
  endtask

  initial begin
    int n;
    bit found;
    wb_rst_i = 1'b0; start_i = 1'b0; smp_we_i = 1'b0;
    smp_addr_i = '0; smp_dat_i = '0; res_addr_i = '0;

    // 1: reset values, start ignored under reset
    repeat (2) @(posedge wb_clk_i); #1;
    start_i = 1'b1;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
    check("rst cyc", 32'(wb.cyc), 0);
    check("rst stb", 32'(wb.stb), 0);
    check("rst we", 32'(wb.we), 0);
    check("rst adr", wb.adr, 0);
    check("rst dat", wb.dat_w, 0);
    check("rst busy", 32'(busy_o), 0);
    check("rst done", 32'(done_o), 0);
    check("rst err", 32'(err_o), 0);
    wb_rst_i = 1'b1;
    clear_slave();
    repeat (3) @(posedge wb_clk_i); #1;
    check("post-rst busy", 32'(busy_o), 0);
    check("post-rst cyc", 32'(wb.cyc), 0);

    // 2: nominal run, ack immediate, data_valid after 10 cycles
    ack_delay = 0; valid_delay = 10;
    load_samples(3, 0);
    clear_slave();
    start_run();
    check("t2 busy on start", 32'(busy_o), 1);
    check("t2 issue cyc low", 32'(wb.cyc), 0);
    @(posedge wb_clk_i); #1;
    check("t2 first cyc", 32'(wb.cyc), 1);
    check("t2 first stb", 32'(wb.stb), 1);
    check("t2 first sel", 32'(wb.sel), 32'hF);
    check("t2 first we", 32'(wb.we), 1);
    check("t2 first adr", wb.adr, TB_BASE + 32'h08);
    check("t2 first dat", wb.dat_w, 0);
    wait_done(2000, n);
    check("t2 done", 32'(done_o), 1);
    check("t2 busy with done", 32'(busy_o), 0);
    @(posedge wb_clk_i); #1;
    check("t2 done pulse", 32'(done_o), 0);
    repeat (3) @(posedge wb_clk_i); #1;
    check("t2 done count", 32'(done_cnt), 1);
    check("t2 0x0C count", 32'(wr0c_cnt), 32);
    for (int k = 0; k < 32; k++)
      check($sformatf("t2 0x0C[%0d]", k), wr0c_dat[k], 32'(k * 3));
    check("t2 next count", 32'(next_cnt), 2);
    check("t2 next first", next_log[0], 1);
    check("t2 next second", next_log[1], 0);
    check("t2 repeated polls", 32'(poll_reads >= 2), 1);
    check_results("t2");

    // 3: ack delayed 3 cycles, plus a start pulse while busy
    ack_delay = 3;
    load_samples(5, 256);
    clear_slave();
    start_run();
    repeat (20) @(posedge wb_clk_i); #1;
    start_run();
    wait_done(3000, n);
    check("t3 done", 32'(done_o), 1);
    repeat (3) @(posedge wb_clk_i); #1;
    check("t3 done count", 32'(done_cnt), 1);
    check("t3 stb min", 32'(stb_min), 4);
    check("t3 stb max", 32'(stb_max), 4);
    check("t3 gap min", 32'(gap_min), 1);
    check("t3 gap max", 32'(gap_max), 1);
    check_results("t3");

    // 4: bus error on the 5th write, then a clean rerun
    ack_delay = 0; err_at = 4;
    load_samples(3, 1);
    clear_slave();
    start_run();
    n = 0;
    while (busy_o === 1'b1 && n < 50) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    repeat (3) @(posedge wb_clk_i); #1;
    check("t4 err", 32'(err_o), 1);
    check("t4 busy", 32'(busy_o), 0);
    check("t4 cyc", 32'(wb.cyc), 0);
    check("t4 no done", 32'(done_cnt), 0);
    check("t4 0x0C count", 32'(wr0c_cnt), 1);
    err_at = -1;
    start_run();
    check("t4 err cleared", 32'(err_o), 0);
    check("t4 busy again", 32'(busy_o), 1);
    wait_done(2000, n);
    check("t4 rerun done", 32'(done_o), 1);
    check("t4 rerun err", 32'(err_o), 0);
    check_results("t4");

    // 5: data_valid never set
    valid_never = 1'b1;
    clear_slave();
    start_run();
`ifdef IIR_WB_MASTER_TIMEOUT_EN
    n = 0;
    while (busy_o === 1'b1 && n < 2000) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    check("t5 poll reads", 32'(poll_reads), 4);
    check("t5 err", 32'(err_o), 1);
    check("t5 busy", 32'(busy_o), 0);
    check("t5 no done", 32'(done_cnt), 0);
`else
    repeat (10000) @(posedge wb_clk_i); #1;
    check("t5 still busy", 32'(busy_o), 1);
    check("t5 no err", 32'(err_o), 0);
    check("t5 no done", 32'(done_cnt), 0);
    check("t5 still polling", 32'(poll_reads > 4), 1);
`endif
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    valid_never = 1'b0;

    // 6: reset during read of result 17, then full run latency
    ack_delay = 3; valid_delay = 0;
    load_samples(2, 5);
    clear_slave();
    start_run();
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(posedge wb_clk_i); #1;
      if (wb.cyc && !wb.we && off == 32'h1C && s_raddr == 32'd17) found = 1'b1;
    end
    check("t6 reached read 17", 32'(found), 1);
    #2;
    wb_rst_i = 1'b0;
    #1;
    check("t6 async cyc", 32'(wb.cyc), 0);
    check("t6 async stb", 32'(wb.stb), 0);
    check("t6 async busy", 32'(busy_o), 0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b1;
    ack_delay = 0;
    clear_slave();
    check("t6 idle after rst", 32'(busy_o), 0);
    start_run();
    wait_done(1000, n);
    check("t6 latency", 32'(n), 391);
    check("t6 done", 32'(done_o), 1);
    check_results("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
